// File: rtl/msg_pkg.sv
// Shared message-format definitions for the coherence-message arbiter:
// type codes, the urgent bit and a field extractor for up to 128-bit messages.
package msg_pkg;

    localparam int TYPE_W     = 4;
    localparam int URG_BIT    = 3;
    localparam int MSG_MAX_W  = 128;
    localparam int ID_MAX_W   = 8;
    localparam int ADDR_MAX_W = 64;

    localparam logic [TYPE_W-1:0] T_GETS = 4'h1;
    localparam logic [TYPE_W-1:0] T_GETM = 4'h2;
    localparam logic [TYPE_W-1:0] T_PUTM = 4'h3;
    localparam logic [TYPE_W-1:0] T_DATA = 4'h9;
    localparam logic [TYPE_W-1:0] T_ACK  = 4'hA;

    typedef struct packed {
        logic [TYPE_W-1:0]     mtype;
        logic [ID_MAX_W-1:0]   src;
        logic [ID_MAX_W-1:0]   dst;
        logic [ADDR_MAX_W-1:0] addr;
    } msg_fields_t;

    // Caller zero-extends the message to MSG_MAX_W; layout is type|src|dst|addr, MSB first.
    function automatic msg_fields_t msg_unpack(input logic [MSG_MAX_W-1:0] msg,
                                               input int idw, input int aw);
        msg_fields_t            f;
        logic [MSG_MAX_W-1:0]   m;
        logic [MSG_MAX_W-1:0]   ones;
        ones    = '1;
        m       = msg;
        f.addr  = ADDR_MAX_W'(m & ~(ones << aw));
        m       = m >> aw;
        f.dst   = ID_MAX_W'(m & ~(ones << idw));
        m       = m >> idw;
        f.src   = ID_MAX_W'(m & ~(ones << idw));
        m       = m >> idw;
        f.mtype = TYPE_W'(m);
        return f;
    endfunction

endpackage

// File: rtl/msg_arb_fifo.sv
// Single-source synchronous FIFO; head entry is visible combinationally on rdata.
module msg_arb_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    // Full blocks push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/msg_arb_q.sv
// Per-source FIFOs drained round-robin into a registered valid/ready output.
// Define MSG_ARB_URGENT_EN to give heads with type[3]=1 priority over requests.
module msg_arb_q
    import msg_pkg::*;
#(
    parameter  int CACHE_NUM  = 2,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int IDW        = $clog2(CACHE_NUM),
    localparam int MSG_W      = 4 + 2*IDW + ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CACHE_NUM-1:0]       in_valid,
    output logic [CACHE_NUM-1:0]       in_ready,
    input  logic [CACHE_NUM*MSG_W-1:0] in_msg,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [MSG_W-1:0]           out_msg,
    output logic [IDW-1:0]             out_src
);

    logic [CACHE_NUM-1:0]            push;
    logic [CACHE_NUM-1:0]            pop;
    logic [CACHE_NUM-1:0]            full;
    logic [CACHE_NUM-1:0]            empty;
    logic [CACHE_NUM-1:0]            req;
    logic [CACHE_NUM-1:0]            sel;
    logic [CACHE_NUM-1:0][MSG_W-1:0] head;
    logic [IDW-1:0]                  last_gnt;
    logic [IDW-1:0]                  win;
    logic [IDW-1:0]                  idx;
    logic                            found;
    logic                            load;
`ifdef MSG_ARB_URGENT_EN
    logic [CACHE_NUM-1:0]            urg;
`endif

    assign in_ready = ~full;
    assign load     = (!out_valid || out_ready) && (|req);

    for (genvar i = 0; i < CACHE_NUM; i++) begin : g_src
        assign push[i] = in_valid[i] && !full[i];
        assign pop[i]  = load && (win == IDW'(i));
        assign req[i]  = !empty[i];
`ifdef MSG_ARB_URGENT_EN
        assign urg[i]  = req[i] &&
            msg_unpack(MSG_MAX_W'(head[i]), IDW, ADDR_WIDTH).mtype[URG_BIT];
`endif
        msg_arb_fifo #(.DEPTH(DEPTH), .W(MSG_W)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata (in_msg[i*MSG_W +: MSG_W]),
            .rdata (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    // One shared pointer serves both priority levels.
    always_comb begin
        sel = req;
`ifdef MSG_ARB_URGENT_EN
        if (|urg) sel = urg;
`endif
        win   = last_gnt;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= CACHE_NUM; k++) begin
            idx = IDW'((int'(last_gnt) + k) % CACHE_NUM);
            if (!found && sel[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_msg   <= '0;
            out_src   <= '0;
            last_gnt  <= IDW'(CACHE_NUM - 1);
        end else if (load) begin
            out_valid <= 1'b1;
            out_msg   <= head[win];
            out_src   <= win;
            last_gnt  <= win;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_msg_arb_q.sv
// Scoreboard bench for msg_arb_q (4 sources, 32-bit address, depth 4).
module tb_msg_arb_q;

    localparam int CN    = 4;
    localparam int AWD   = 32;
    localparam int DP    = 4;
    localparam int IDW   = 2;
    localparam int MSG_W = 4 + 2*IDW + AWD;

    logic                  clk;
    logic                  rst_n;
    logic [CN-1:0]         in_valid;
    logic [CN-1:0]         in_ready;
    logic [CN*MSG_W-1:0]   in_msg;
    logic                  out_valid;
    logic                  out_ready;
    logic [MSG_W-1:0]      out_msg;
    logic [IDW-1:0]        out_src;

    int                    n_cmp = 0;
    int                    n_err = 0;
    int                    seq   = 0;
    logic [MSG_W-1:0]      sb [CN][$];
    logic [IDW-1:0]        src_log [$];
    logic [MSG_W-1:0]      exp_bp;

    msg_arb_q #(.CACHE_NUM(CN), .ADDR_WIDTH(AWD), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_msg    (in_msg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_msg   (out_msg),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [MSG_W-1:0] mk(input logic [3:0] t, input logic [1:0] s,
                                            input logic [1:0] d, input logic [31:0] a);
        return {t, s, d, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        for (int i = 0; i < CN; i++) sb[i].delete();
        src_log.delete();
    endtask

    // Record every message the DUT will take on the coming edge, then clock it in.
    task automatic commit();
        for (int i = 0; i < CN; i++)
            if (in_valid[i] && in_ready[i]) sb[i].push_back(in_msg[i*MSG_W +: MSG_W]);
        tick();
        in_valid = '0;
    endtask

    task automatic push_cycle(input logic [CN-1:0] vm, input logic [3:0] t);
        for (int i = 0; i < CN; i++) begin
            if (vm[i]) begin
                in_valid[i] = 1'b1;
                in_msg[i*MSG_W +: MSG_W] = mk(t, 2'(i), 2'(3 - i), 32'h100 * seq + i);
            end
        end
        seq++;
        commit();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        clear_sb();
        repeat (2) tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_drained(input string tag);
        for (int i = 0; i < CN; i++) chk(tag, 64'(sb[i].size()), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            src_log.push_back(out_src);
            chk("sb_avail", 64'(sb[out_src].size() > 0), 1);
            if (sb[out_src].size() > 0) chk("sb_msg", out_msg, sb[out_src].pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_msg    = '0;
        out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_msg",   64'(out_msg),   0);
        chk("rst_out_src",   64'(out_src),   0);
        chk("rst_in_ready",  64'(in_ready),  64'hF);
        do_reset();

        // single source latency
        out_ready = 1'b1;
        in_valid[2] = 1'b1;
        in_msg[2*MSG_W +: MSG_W] = mk(4'h1, 2'd2, 2'd0, 32'h1000);
        commit();
        chk("lat_early", 64'(out_valid), 0);
        tick();
        chk("lat_valid", 64'(out_valid), 1);
        chk("lat_src",   64'(out_src),   2);
        chk("lat_addr",  64'(out_msg[31:0]), 64'h1000);
        tick();
        chk("lat_drop",  64'(out_valid), 0);
        chk_drained("lat_sb");

        // fairness over 12 preloaded messages
        do_reset();
        repeat (3) push_cycle(4'hF, 4'h1);
        src_log.delete();
        out_ready = 1'b1;
        repeat (12) tick();
        chk("fair_n", 64'(src_log.size()), 12);
        for (int i = 0; i < 12 && i < src_log.size(); i++) chk("fair_src", 64'(src_log[i]), 64'(i % CN));
        chk("fair_idle", 64'(out_valid), 0);
        chk_drained("fair_sb");

        // back-pressure holds output stable
        do_reset();
        repeat (2) push_cycle(4'b0111, 4'h2);
        exp_bp = sb[0][0];
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_valid", 64'(out_valid), 1);
            chk("bp_msg",   64'(out_msg),   64'(exp_bp));
            chk("bp_src",   64'(out_src),   0);
        end
        src_log.delete();
        out_ready = 1'b1;
        repeat (7) tick();
        chk("bp_n", 64'(src_log.size()), 6);
        for (int i = 0; i < 6 && i < src_log.size(); i++) chk("bp_order", 64'(src_log[i]), 64'(i % 3));
        chk_drained("bp_sb");

        // full FIFO refuses the fifth push
        do_reset();
        in_valid[0] = 1'b1;
        in_msg[0 +: MSG_W] = mk(4'h1, 2'd0, 2'd1, 32'h3000);
        commit();
        tick();
        for (int k = 0; k < 5; k++) begin
            in_valid[1] = 1'b1;
            in_msg[MSG_W +: MSG_W] = mk(4'h2, 2'd1, 2'd0, 32'h2000 + k);
            chk("full_rdy", 64'(in_ready[1]), 64'(k < 4));
            commit();
        end
        chk("full_rdy_end", 64'(in_ready[1]), 0);
        src_log.delete();
        out_ready = 1'b1;
        repeat (7) tick();
        chk("full_n", 64'(src_log.size()), 5);
        for (int i = 0; i < 5 && i < src_log.size(); i++) chk("full_src", 64'(src_log[i]), 64'(i > 0));
        chk_drained("full_sb");

        // urgent response vs request with last_gnt = 3
        do_reset();
        in_valid = 4'b1001;
        in_msg[0 +: MSG_W]       = mk(4'h1, 2'd0, 2'd1, 32'h4000);
        in_msg[3*MSG_W +: MSG_W] = mk(4'h9, 2'd3, 2'd1, 32'h4300);
        commit();
        tick();
        chk("urg_valid", 64'(out_valid), 1);
`ifdef MSG_ARB_URGENT_EN
        chk("urg_first", 64'(out_src), 3);
`else
        chk("urg_first", 64'(out_src), 0);
`endif
        out_ready = 1'b1;
        repeat (3) tick();
        chk_drained("urg_sb");

        // asynchronous reset mid-traffic
        do_reset();
        repeat (2) push_cycle(4'b0111, 4'h1);
        chk("mid_valid_pre", 64'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid",    64'(out_valid), 0);
        chk("mid_in_ready", 64'(in_ready),  64'hF);
        clear_sb();
        tick();
        #2 rst_n = 1'b1;
        tick();
        push_cycle(4'hF, 4'h1);
        tick();
        chk("mid_first_v",   64'(out_valid), 1);
        chk("mid_first_src", 64'(out_src),   0);
        out_ready = 1'b1;
        repeat (5) tick();
        chk_drained("mid_sb");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
